// File: rtl/program_loader_pkg.sv
// Shared FSM encodings and word-geometry helper for the program loader.
package program_loader_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_RUN  = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    function automatic int bytes_per_word(input int instr_w);
        return (instr_w + 7) / 8;
    endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs MSB-first bytes into instruction words; word_vld one cycle after the last byte.
// Latency 1 cycle from last byte to word_vld; no backpressure, caller gates byte_vld.
// clear restarts word alignment without emitting a partial word.
module program_loader_byte_packer #(
    parameter int INSTR_W = 8,
    parameter int BPI     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               byte_vld,
    input  logic [7:0]         byte_dat,
    output logic               last_byte,
    output logic               word_vld,
    output logic [INSTR_W-1:0] word_dat
);

    localparam int PW = BPI * 8;
    localparam int CW = (BPI > 1) ? $clog2(BPI) : 1;

    logic [CW-1:0] cnt;
    logic [PW-1:0] sr;
    logic [PW-1:0] sr_next;

    assign last_byte = (cnt == CW'(BPI - 1));
    assign sr_next   = (sr << 8) | PW'(byte_dat);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            sr       <= '0;
            word_vld <= 1'b0;
            word_dat <= '0;
        end else begin
            word_vld <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (byte_vld) begin
                sr <= sr_next;
                if (last_byte) begin
                    cnt      <= '0;
                    word_vld <= 1'b1;
                    // Bits above INSTR_W belong to the leading byte and are dropped.
                    word_dat <= INSTR_W'(sr_next);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a framed, checksummed byte stream into program RAM and gates the processor.
// Latency: RAM write 1 cycle after a word's last byte; load_done 1 cycle after CSUM.
// Backpressure: in_ready only in LEN/DATA/CSUM and never while load_start is high.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int INSTR_W = 8,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int          BPI   = bytes_per_word(INSTR_W);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [2:0]        state;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] last_idx;
    logic              accept;
    logic              last_byte;
    logic              word_done;

    assign in_ready  = ((state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM)) && !load_start;
    assign accept    = in_valid && in_ready;
    assign word_done = accept && (state == ST_DATA) && last_byte;
    assign cpu_run   = (state == ST_RUN);
    assign load_err  = (state == ST_ERR);

    program_loader_byte_packer #(
        .INSTR_W (INSTR_W),
        .BPI     (BPI)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (load_start),
        .byte_vld  (accept && (state == ST_DATA)),
        .byte_dat  (in_data),
        .last_byte (last_byte),
        .word_vld  (mem_we),
        .word_dat  (mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            csum         <= '0;
            word_idx     <= '0;
            last_idx     <= '0;
            mem_addr     <= '0;
            words_loaded <= '0;
            load_done    <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (word_done) begin
                mem_addr <= word_idx;
            end
            if (load_start) begin
                state        <= ST_LEN;
                csum         <= '0;
                word_idx     <= '0;
                words_loaded <= '0;
            end else begin
                if (mem_we) begin
                    words_loaded <= words_loaded + 1'b1;
                end
                case (state)
                    ST_LEN: begin
                        if (accept) begin
                            csum <= in_data;
                            if (32'(in_data) > DEPTH) begin
                                state <= ST_ERR;
                            end else begin
                                // LEN of zero means a full memory image.
                                last_idx <= (in_data == 8'd0) ? '1 : ADDR_W'(in_data - 8'd1);
                                state    <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (accept) begin
                            csum <= csum + in_data;
                        end
                        if (word_done) begin
                            word_idx <= word_idx + 1'b1;
                            if (word_idx == last_idx) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (accept) begin
                            if (in_data == csum) begin
                                state     <= ST_RUN;
                                load_done <= 1'b1;
                            end else begin
                                state <= ST_ERR;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame table plus hand-written timing/abort/reset cases.
module tb_program_loader;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, load_start, in_valid;
    logic [7:0] in_data;

    logic       in_ready, mem_we, cpu_run, load_done, load_err;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [5:0] words_loaded;

    logic        r12, we12, run12, done12, err12;
    logic [4:0]  a12;
    logic [11:0] wd12;
    logic [5:0]  wl12;

    program_loader #(.INSTR_W(8), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_run(cpu_run), .load_done(load_done),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    program_loader #(.INSTR_W(12), .ADDR_W(5)) dut12 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(r12), .mem_we(we12), .mem_addr(a12),
        .mem_wdata(wd12), .cpu_run(run12), .load_done(done12),
        .load_err(err12), .words_loaded(wl12)
    );

    int checks = 0;
    int errors = 0;
    logic use12 = 1'b0;

    logic [4:0]  wa_q[$];
    logic [7:0]  wd_q[$];
    logic [4:0]  wa12_q[$];
    logic [11:0] wd12_q[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (we12 === 1'b1) begin
            wa12_q.push_back(a12);
            wd12_q.push_back(wd12);
        end
        if (load_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wa12_q.delete(); wd12_q.delete();
    endtask

    task automatic start_frame();
        load_start = 1'b1;
        in_valid   = 1'b0;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gaps, input string name);
        logic got;
        int   tries;
        in_valid = 1'b0;
        repeat (gaps) tick();
        in_data  = b;
        in_valid = 1'b1;
        got      = 1'b0;
        tries    = 0;
        while (!got && tries < 20) begin
            @(negedge clk);
            got = use12 ? r12 : in_ready;
            tick();
            tries++;
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s byte %0h not accepted: in_ready=0 required=1", name, b);
        end
    endtask

    typedef struct packed {
        logic [47:0] bytes;   // frame bytes, first byte in the top octet
        logic [3:0]  nb;
        logic [3:0]  nw;
        logic [31:0] wdat;    // expected written words, first in the top octet
        logic        run;
        logic        err;
        logic        done;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int bad;
        int base;

        vecs[0] = '{48'h03_11_22_33_69_00, 4'd5, 4'd3, 32'h11_22_33_00, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{48'h03_11_22_33_68_00, 4'd5, 4'd3, 32'h11_22_33_00, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{48'h21_00_00_00_00_00, 4'd1, 4'd0, 32'h00_00_00_00, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{48'h01_A5_A6_00_00_00, 4'd3, 4'd1, 32'hA5_00_00_00, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{48'h02_FF_02_03_00_00, 4'd4, 4'd2, 32'hFF_02_00_00, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{48'h04_01_02_03_04_0E, 4'd6, 4'd4, 32'h01_02_03_04, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{48'h02_10_20_31_00_00, 4'd4, 4'd2, 32'h10_20_00_00, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        @(negedge clk);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst cpu_run", cpu_run, 0);
        chk("rst load_done", load_done, 0);
        chk("rst load_err", load_err, 0);
        chk("rst words_loaded", words_loaded, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst wdata12", wd12, 0);
        tick();
        rst_n = 1'b1;

        // Bytes offered while idle must be ignored.
        in_valid = 1'b1; in_data = 8'h55;
        tick(); tick();
        @(negedge clk);
        chk("idle in_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        chk("idle no writes", wa_q.size(), 0);

        // Write timing: each strobe in the cycle right after the word's byte.
        clear_log();
        start_frame();
        in_valid = 1'b1; in_data = 8'h03;
        tick();
        in_data = 8'h11;
        @(negedge clk);
        chk("t1 no we after LEN", mem_we, 0);
        tick();
        in_data = 8'h22;
        @(negedge clk);
        chk("t1 we0", {mem_we, mem_addr, mem_wdata}, {1'b1, 5'd0, 8'h11});
        tick();
        in_data = 8'h33;
        @(negedge clk);
        chk("t1 we1", {mem_we, mem_addr, mem_wdata}, {1'b1, 5'd1, 8'h22});
        tick();
        in_data = 8'h69;
        @(negedge clk);
        chk("t1 we2", {mem_we, mem_addr, mem_wdata}, {1'b1, 5'd2, 8'h33});
        chk("t1 held during load", cpu_run, 0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1 done pulse", {load_done, cpu_run, mem_we}, {1'b1, 1'b1, 1'b0});
        chk("t1 words_loaded", words_loaded, 3);
        tick();
        @(negedge clk);
        chk("t1 done one cycle", {load_done, cpu_run}, {1'b0, 1'b1});
        tick();

        // Table: pass 0 streams back to back, pass 1 inserts random idle gaps.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 7; i++) begin
                vec_t v;
                v = vecs[i];
                clear_log();
                base = done_cnt;
                start_frame();
                for (int k = 0; k < int'(v.nb); k++)
                    send(v.bytes[47-8*k -: 8], pass ? int'($urandom_range(0, 3)) : 0,
                         $sformatf("p%0d v%0d", pass, i));
                tick(); tick(); tick();
                chk($sformatf("p%0d v%0d nwrites", pass, i), wa_q.size(), v.nw);
                bad = 0;
                for (int j = 0; j < wa_q.size() && j < int'(v.nw); j++)
                    if (wa_q[j] !== 5'(j) || wd_q[j] !== v.wdat[31-8*j -: 8]) bad++;
                chk($sformatf("p%0d v%0d write contents", pass, i), bad, 0);
                chk($sformatf("p%0d v%0d run/err", pass, i), {cpu_run, load_err}, {v.run, v.err});
                chk($sformatf("p%0d v%0d done count", pass, i), done_cnt - base, v.done);
                chk($sformatf("p%0d v%0d words_loaded", pass, i), words_loaded, v.nw);
                chk($sformatf("p%0d v%0d in_ready after", pass, i), in_ready, 0);
            end
        end

        // Oversized LEN errors on the following cycle.
        clear_log();
        start_frame();
        in_valid = 1'b1; in_data = 8'h21;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("len21 err next cycle", {load_err, cpu_run, in_ready}, {1'b1, 1'b0, 1'b0});
        tick();

        // LEN=0 loads the full memory.
        clear_log();
        start_frame();
        send(8'h00, 0, "len0 len");
        for (int k = 0; k < 32; k++) send(8'h01, k % 5 == 3 ? 1 : 0, "len0 data");
        send(8'h20, 0, "len0 csum");
        tick(); tick();
        chk("len0 nwrites", wa_q.size(), 32);
        bad = 0;
        for (int j = 0; j < wa_q.size(); j++)
            if (wa_q[j] !== 5'(j) || wd_q[j] !== 8'h01) bad++;
        chk("len0 addr/data seq", bad, 0);
        chk("len0 cpu_run", {cpu_run, load_err}, {1'b1, 1'b0});
        chk("len0 words_loaded", words_loaded, 32);

        // Abort in DATA after two words; byte offered alongside load_start is refused.
        start_frame();
        send(8'h04, 0, "abort len");
        send(8'h01, 0, "abort d0");
        send(8'h02, 0, "abort d1");
        load_start = 1'b1; in_valid = 1'b1; in_data = 8'h99;
        @(negedge clk);
        chk("abort in_ready with load_start", in_ready, 0);
        tick();
        load_start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("abort cleared", {cpu_run, load_err, in_ready}, {1'b0, 1'b0, 1'b1});
        chk("abort words_loaded", words_loaded, 0);
        tick();
        clear_log();
        send(8'h02, 0, "reload len");
        send(8'hAA, 0, "reload d0");
        send(8'hBB, 0, "reload d1");
        send(8'h67, 0, "reload csum");
        tick(); tick();
        chk("reload nwrites", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            chk("reload w0", {wa_q[0], wd_q[0]}, {5'd0, 8'hAA});
            chk("reload w1", {wa_q[1], wd_q[1]}, {5'd1, 8'hBB});
        end
        chk("reload run", cpu_run, 1);

        // load_start from RUN drops cpu_run next cycle.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        @(negedge clk);
        chk("run abort", {cpu_run, in_ready, words_loaded}, {1'b0, 1'b1, 6'd0});
        tick();

        // Reset mid-frame discards everything.
        send(8'h02, 0, "rst len");
        send(8'h11, 0, "rst d0");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst outputs", {mem_we, mem_addr, mem_wdata, cpu_run, load_done, load_err, words_loaded, in_ready}, 0);
        tick();
        clear_log();
        in_valid = 1'b1; in_data = 8'h01;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("midrst bytes ignored", {wa_q.size() == 0, cpu_run, load_err}, {1'b1, 1'b0, 1'b0});
        start_frame();
        send(8'h01, 0, "post len");
        send(8'h5A, 0, "post d0");
        send(8'h5B, 0, "post csum");
        tick();
        chk("post reset load", {wa_q.size() == 1, cpu_run}, {1'b1, 1'b1});
        if (wa_q.size() == 1) chk("post reset word", {wa_q[0], wd_q[0]}, {5'd0, 8'h5A});

        // 12-bit build: two bytes per word, top nibble of first byte dropped.
        clear_log();
        use12 = 1'b1;
        start_frame();
        send(8'h01, 0, "w12 len");
        send(8'h0A, 0, "w12 b0");
        send(8'hBC, 0, "w12 b1");
        send(8'hC7, 0, "w12 csum");
        use12 = 1'b0;
        tick(); tick();
        chk("w12 nwrites", wa12_q.size(), 1);
        if (wa12_q.size() == 1) chk("w12 word", {wa12_q[0], wd12_q[0]}, {5'd0, 12'hABC});
        chk("w12 run", {run12, err12, wl12}, {1'b1, 1'b0, 6'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
